// File: rtl/onehot_rr_arbiter_if.sv
// Bus-side signals of the one-hot round-robin arbiter.
//
// Ports (as interface signals):
//   req          requester -> arbiter   N_REQ  request vector
//   done         requester -> arbiter   1      completion of the granted transaction
//   grant        arbiter -> requester   N_REQ  registered one-hot grant (zero when idle)
//   grant_valid  arbiter -> requester   1      high iff grant != 0
//   grant_idx    arbiter -> requester   W_IDX  binary index of the granted bit (0 when idle)
//
// Handshake: a grant is issued on a clock edge and stays frozen until the
// edge on which done=1 is sampled; on that edge the arbiter either hands the
// bus to the next requester (no idle cycle) or drops to zero. done sampled
// while grant_valid=0 has no effect. There is no ready: the grantee owns the
// bus from the grant edge until its done edge.
interface onehot_rr_arbiter_if #(
  parameter int N_REQ = 4
);
  localparam int W_IDX = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0] req;
  logic             done;
  logic [N_REQ-1:0] grant;
  logic             grant_valid;
  logic [W_IDX-1:0] grant_idx;

  modport master (
    output req,
    output done,
    input  grant,
    input  grant_valid,
    input  grant_idx
  );

  modport slave (
    input  req,
    input  done,
    output grant,
    output grant_valid,
    output grant_idx
  );
endinterface

// File: rtl/onehot_rr_arbiter.sv
// Round-robin arbiter producing a registered one-hot select for an and-or
// mux. A grant is held until the grantee pulses done, then priority rotates
// past the finished grantee and the next winner is granted on the same edge.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   bus        slave modport of onehot_rr_arbiter_if (req/done in,
//              grant/grant_valid/grant_idx out)
//   state_dbg  out  FSM state, 0 = IDLE, 1 = BUSY
module onehot_rr_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  onehot_rr_arbiter_if.slave      bus,
  output logic                    state_dbg
);
  localparam int W_IDX = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [W_IDX-1:0] idx_q, idx_d;
  logic             valid_q, valid_d;
  logic [W_IDX-1:0] ptr_q, ptr_d;

  // Priority base following the current grantee, wrapping N_REQ-1 -> 0.
  logic [W_IDX-1:0] idx_inc;
  logic [W_IDX-1:0] base;
  logic [N_REQ-1:0] rot;
  logic             win_found;
  logic [W_IDX-1:0] win_idx;
  logic [N_REQ-1:0] win_onehot;

  assign idx_inc = W_IDX'((int'(idx_q) + 1) % N_REQ);

  // In IDLE the search starts at the stored pointer; in BUSY it only matters
  // on a done edge, where the new pointer is the grantee index + 1.
  assign base = (state_q == BUSY) ? idx_inc : ptr_q;

  // Rotate req so that bit 'base' lands at position 0, then take the lowest
  // set bit and translate its position back into an absolute index.
  always_comb begin
    rot       = N_REQ'({bus.req, bus.req} >> base);
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!win_found && rot[k]) begin
        win_found = 1'b1;
        win_idx   = W_IDX'((int'(base) + k) % N_REQ);
      end
    end
  end

  assign win_onehot = N_REQ'(1) << win_idx;

  // State register together with the registered outputs it controls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (win_found) state_d = BUSY;
      BUSY: if (bus.done && !win_found) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs and the priority pointer. While
  // BUSY without done everything holds, so req changes are ignored.
  always_comb begin
    grant_d = grant_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          grant_d = win_onehot;
          idx_d   = win_idx;
        end
      end
      BUSY: begin
        if (bus.done) begin
          ptr_d = idx_inc;
          if (win_found) begin
            grant_d = win_onehot;
            idx_d   = win_idx;
          end else begin
            grant_d = '0;
            idx_d   = '0;
          end
        end
      end
      default: begin
        grant_d = '0;
        idx_d   = '0;
      end
    endcase
    valid_d = |grant_d;
  end

  assign bus.grant       = grant_q;
  assign bus.grant_valid = valid_q;
  assign bus.grant_idx   = idx_q;
  assign state_dbg       = (state_q == BUSY);

endmodule

// File: tb/tb_onehot_rr_arbiter.sv
// Bench for onehot_rr_arbiter: three instances (N_REQ = 4, 3, 1) share a
// clock and reset. Directed scenarios run on the 4-requester instance, then
// all three receive random req/done traffic. Every output is compared at the
// falling edge against a behavioural model of the round-robin rules.
module tb_onehot_rr_arbiter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  localparam int NI = 3;
  int n_of [NI] = '{4, 3, 1};

  logic [3:0] drv_req  [NI];
  logic       drv_done [NI];

  onehot_rr_arbiter_if #(.N_REQ(4)) if4 ();
  onehot_rr_arbiter_if #(.N_REQ(3)) if3 ();
  onehot_rr_arbiter_if #(.N_REQ(1)) if1 ();

  logic dbg4, dbg3, dbg1;

  assign if4.req  = drv_req[0];
  assign if3.req  = drv_req[1][2:0];
  assign if1.req  = drv_req[2][0];
  assign if4.done = drv_done[0];
  assign if3.done = drv_done[1];
  assign if1.done = drv_done[2];

  onehot_rr_arbiter #(.N_REQ(4)) u_arb4 (.clk(clk), .rst_n(rst_n), .bus(if4), .state_dbg(dbg4));
  onehot_rr_arbiter #(.N_REQ(3)) u_arb3 (.clk(clk), .rst_n(rst_n), .bus(if3), .state_dbg(dbg3));
  onehot_rr_arbiter #(.N_REQ(1)) u_arb1 (.clk(clk), .rst_n(rst_n), .bus(if1), .state_dbg(dbg1));

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // busy/owner/ptr describe the arbiter in terms of who owns the bus and
  // where the next search starts.
  bit m_busy  [NI];
  int m_owner [NI];
  int m_ptr   [NI];

  // Observation history for the hold and fairness properties.
  logic [31:0] last_grant [NI];
  bit          last_valid [NI];
  bit          edge_done  [NI];
  logic [3:0]  edge_req   [NI];
  int          wait_cnt   [NI][4];

  // First requester at or after base, going round the ring.
  function automatic int rr_ref(input int n, input logic [3:0] r, input int base);
    for (int k = 0; k < n; k++) begin
      int p;
      p = (base + k) % n;
      if (r[p]) return p;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      m_busy[i] = 0;
      m_owner[i] = 0;
      m_ptr[i] = 0;
      last_grant[i] = '0;
      last_valid[i] = 0;
      for (int j = 0; j < 4; j++) wait_cnt[i][j] = 0;
    end
  endtask

  task automatic model_step(input int i);
    int w;
    edge_done[i] = drv_done[i];
    edge_req[i]  = drv_req[i];
    for (int j = 0; j < n_of[i]; j++)
      if (!drv_req[i][j]) wait_cnt[i][j] = 0;
    if (!m_busy[i]) begin
      w = rr_ref(n_of[i], drv_req[i], m_ptr[i]);
      if (w >= 0) begin
        m_busy[i] = 1;
        m_owner[i] = w;
      end
    end else if (drv_done[i]) begin
      m_ptr[i] = (m_owner[i] + 1) % n_of[i];
      w = rr_ref(n_of[i], drv_req[i], m_ptr[i]);
      if (w >= 0) m_owner[i] = w;
      else begin
        m_busy[i] = 0;
        m_owner[i] = 0;
      end
    end
  endtask

  task automatic check_inst(input int i);
    logic [31:0] g, idx;
    bit v, dbg;
    string s;
    case (i)
      0: begin g = 32'(if4.grant); v = if4.grant_valid; idx = 32'(if4.grant_idx); dbg = dbg4; end
      1: begin g = 32'(if3.grant); v = if3.grant_valid; idx = 32'(if3.grant_idx); dbg = dbg3; end
      default: begin g = 32'(if1.grant); v = if1.grant_valid; idx = 32'(if1.grant_idx); dbg = dbg1; end
    endcase
    s = $sformatf("n%0d", n_of[i]);
    check({s, "_grant"}, g, m_busy[i] ? (32'd1 << m_owner[i]) : 32'd0);
    check({s, "_valid"}, 32'(v), 32'(m_busy[i]));
    check({s, "_idx"}, idx, m_busy[i] ? 32'(m_owner[i]) : 32'd0);
    check({s, "_state"}, 32'(dbg), 32'(m_busy[i]));
    check({s, "_onehot0"}, 32'($onehot0(g)), 32'd1);
    check({s, "_valid_or"}, 32'(v), 32'(|g));
    if (last_valid[i] && !edge_done[i])
      check({s, "_hold"}, g, last_grant[i]);
    // A new grant was issued on this edge: everyone else still holding req
    // has now waited one more grant.
    if (v && (!last_valid[i] || edge_done[i])) begin
      for (int j = 0; j < n_of[i]; j++) begin
        if (32'(j) == idx) wait_cnt[i][j] = 0;
        else if (edge_req[i][j]) begin
          wait_cnt[i][j]++;
          check({s, "_fair"}, 32'(wait_cnt[i][j] <= n_of[i]), 32'd1);
        end
      end
    end
    last_grant[i] = g;
    last_valid[i] = v;
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < NI; i++) model_step(i);
    @(negedge clk);
    for (int i = 0; i < NI; i++) check_inst(i);
  endtask

  task automatic drive4(input logic [3:0] r, input logic d);
    drv_req[0] = r;
    drv_done[0] = d;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < NI; i++) begin
      drv_req[i] = '0;
      drv_done[i] = 1'b0;
    end
    model_reset();
    #12;
    check("rst_grant", 32'(if4.grant), 32'd0);
    check("rst_valid", 32'(if4.grant_valid), 32'd0);
    check("rst_idx", 32'(if4.grant_idx), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Scenario 1: first grant after reset, then frozen.
    drive4(4'b1010, 1'b0);
    tick();
    check("s1_grant", 32'(if4.grant), 32'b0010);
    check("s1_idx", 32'(if4.grant_idx), 32'd1);
    repeat (5) tick();
    check("s1_frozen", 32'(if4.grant), 32'b0010);

    // Scenario 2: rotation with wrap-around.
    drive4(4'b1011, 1'b1);
    tick();
    check("s2_g3", 32'(if4.grant), 32'b1000);
    tick();
    check("s2_wrap", 32'(if4.grant), 32'b0001);
    tick();
    check("s2_g1", 32'(if4.grant), 32'b0010);

    // Scenario 3: sole requester re-granted back-to-back, then drop to idle.
    drive4(4'b0100, 1'b1);
    repeat (3) begin
      tick();
      check("s3_b2b", 32'(if4.grant), 32'b0100);
    end
    drive4(4'b0000, 1'b1);
    tick();
    check("s3_idle_grant", 32'(if4.grant), 32'd0);
    check("s3_idle_valid", 32'(if4.grant_valid), 32'd0);

    // Scenario 4: grantee drops req while busy; done in idle is ignored.
    drive4(4'b0100, 1'b0);
    tick();
    check("s4_grant", 32'(if4.grant), 32'b0100);
    drive4(4'b0000, 1'b0);
    tick();
    check("s4_held", 32'(if4.grant), 32'b0100);
    drive4(4'b0000, 1'b1);
    tick();
    check("s4_idle", 32'(if4.grant_valid), 32'd0);
    repeat (2) tick();
    check("s4_idle_done", 32'(if4.grant), 32'd0);
    drive4(4'b1111, 1'b0);
    tick();
    check("s4_ptr3", 32'(if4.grant), 32'b1000);

    // Scenario 5: asynchronous reset in the middle of a busy phase.
    #2 rst_n = 1'b0;
    #1;
    check("s5_async_grant", 32'(if4.grant), 32'd0);
    check("s5_async_valid", 32'(if4.grant_valid), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("s5_after_rst", 32'(if4.grant), 32'b0001);

    // Scenario 6: random traffic on all instances.
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < NI; i++) begin
        for (int j = 0; j < n_of[i]; j++)
          if ($urandom_range(3, 0) == 0) drv_req[i][j] = ~drv_req[i][j];
        for (int j = n_of[i]; j < 4; j++) drv_req[i][j] = 1'b0;
        drv_done[i] = ($urandom_range(2, 0) == 0);
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
